// File: rtl/core_mem_arb.sv
// -----------------------------------------------------------------------------
// core_mem_arb
//
// Arbitrates between an instruction-fetch unit (IFU) and a load/store unit
// (LSU) for a single downstream memory port. Only one transaction may be
// outstanding. LSU normally has priority. The IFU is protected from
// starvation: after STARVE_MAX back-to-back LSU grants taken while the IFU
// was waiting, the IFU wins the next arbitration. A response timeout
// returns an error response to the owner if memory never answers.
//
// Ports
//   clk, rst_n                   clock, asynchronous active-low reset
//   ifu_req_valid/ready/addr     fetch request handshake (read only)
//   lsu_req_valid/ready/addr     load/store request handshake
//   lsu_req_wen/wdata/wmask      store qualifier, data and byte mask
//   ifu_rsp_valid, lsu_rsp_valid one-cycle response pulse to the owner
//   rsp_data, rsp_err            shared response data / timeout flag
//   mem_req_valid/ready          downstream request handshake
//   mem_req_addr/wen/wdata/wmask latched downstream request fields
//   mem_rsp_valid, mem_rsp_data  downstream response
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no transaction; ready shown to the arbitration winner
// REQ   | mem_req_valid high with latched fields, waiting for mem_req_ready
// WAIT  | request accepted, waiting for mem_rsp_valid or the timeout
// -----------------------------------------------------------------------------
module core_mem_arb #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 64,
  parameter int STARVE_MAX = 4,
  parameter int TMO_CYC    = 255
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [ADDR_W-1:0] ifu_req_addr,

  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic [ADDR_W-1:0] lsu_req_addr,
  input  logic              lsu_req_wen,
  input  logic [DATA_W-1:0] lsu_req_wdata,
  input  logic [7:0]        lsu_req_wmask,

  output logic              ifu_rsp_valid,
  output logic              lsu_rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,

  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic              mem_req_wen,
  output logic [DATA_W-1:0] mem_req_wdata,
  output logic [7:0]        mem_req_wmask,

  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_data
);

  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_e;

  state_e            state_q;
  owner_e            owner_q;
  logic [SW-1:0]     starve_cnt_q;
  logic [SW-1:0]     starve_cnt_d;
  logic [7:0]        tmo_cnt_q;

  logic              ifu_rsp_valid_q;
  logic              lsu_rsp_valid_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic              rsp_err_q;

  logic              mem_req_valid_q;
  logic [ADDR_W-1:0] mem_req_addr_q;
  logic              mem_req_wen_q;
  logic [DATA_W-1:0] mem_req_wdata_q;
  logic [7:0]        mem_req_wmask_q;

  logic              starve_hit;
  logic              ifu_win;
  logic              lsu_win;
  logic              ifu_gnt;
  logic              lsu_gnt;
  logic              tmo_hit;

  // Arbitration. The two win terms are mutually exclusive: IFU can only win
  // against a valid LSU when the starve counter is saturated, which in turn
  // blocks the LSU.
  always_comb begin
    starve_hit = (starve_cnt_q == SW'(STARVE_MAX));
    ifu_win    = ifu_req_valid & (~lsu_req_valid | starve_hit);
    lsu_win    = lsu_req_valid & ~(ifu_req_valid & starve_hit);
    // rst_n gating keeps the readies low while reset is held, even though
    // IDLE is also the reset state.
    ifu_req_ready = rst_n & (state_q == ST_IDLE) & ifu_win;
    lsu_req_ready = rst_n & (state_q == ST_IDLE) & lsu_win;
    ifu_gnt    = ifu_req_ready;
    lsu_gnt    = lsu_req_ready;
    tmo_hit    = (tmo_cnt_q == 8'(TMO_CYC));
  end

  // Starvation counter: counts LSU grants taken while the IFU was waiting,
  // saturating at STARVE_MAX; any IFU grant clears it.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (ifu_gnt) begin
      starve_cnt_d = '0;
    end else if (lsu_gnt && ifu_req_valid && !starve_hit) begin
      starve_cnt_d = starve_cnt_q + SW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      owner_q         <= OWN_IFU;
      starve_cnt_q    <= '0;
      tmo_cnt_q       <= '0;
      ifu_rsp_valid_q <= 1'b0;
      lsu_rsp_valid_q <= 1'b0;
      rsp_data_q      <= '0;
      rsp_err_q       <= 1'b0;
      mem_req_valid_q <= 1'b0;
      mem_req_addr_q  <= '0;
      mem_req_wen_q   <= 1'b0;
      mem_req_wdata_q <= '0;
      mem_req_wmask_q <= '0;
    end else begin
      // Response pulses are single-cycle by default.
      ifu_rsp_valid_q <= 1'b0;
      lsu_rsp_valid_q <= 1'b0;
      starve_cnt_q    <= starve_cnt_d;

      case (state_q)
        ST_IDLE: begin
          if (lsu_gnt) begin
            owner_q         <= OWN_LSU;
            mem_req_addr_q  <= lsu_req_addr;
            mem_req_wen_q   <= lsu_req_wen;
            mem_req_wdata_q <= lsu_req_wdata;
            mem_req_wmask_q <= lsu_req_wmask;
            mem_req_valid_q <= 1'b1;
            state_q         <= ST_REQ;
          end else if (ifu_gnt) begin
            owner_q         <= OWN_IFU;
            mem_req_addr_q  <= ifu_req_addr;
            mem_req_wen_q   <= 1'b0;
            mem_req_wdata_q <= '0;
            mem_req_wmask_q <= '0;
            mem_req_valid_q <= 1'b1;
            state_q         <= ST_REQ;
          end
        end

        ST_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid_q <= 1'b0;
            tmo_cnt_q       <= '0;
            state_q         <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          // tmo_cnt is 0 in the first WAIT cycle, so the timeout fires in
          // the WAIT cycle where it equals TMO_CYC. A response in that same
          // cycle still takes priority.
          if (mem_rsp_valid) begin
            rsp_data_q      <= mem_rsp_data;
            rsp_err_q       <= 1'b0;
            ifu_rsp_valid_q <= (owner_q == OWN_IFU);
            lsu_rsp_valid_q <= (owner_q == OWN_LSU);
            state_q         <= ST_IDLE;
          end else if (tmo_hit) begin
            rsp_data_q      <= '0;
            rsp_err_q       <= 1'b1;
            ifu_rsp_valid_q <= (owner_q == OWN_IFU);
            lsu_rsp_valid_q <= (owner_q == OWN_LSU);
            state_q         <= ST_IDLE;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 8'd1;
          end
        end

        default: begin
          mem_req_valid_q <= 1'b0;
          state_q         <= ST_IDLE;
        end
      endcase
    end
  end

  assign ifu_rsp_valid = ifu_rsp_valid_q;
  assign lsu_rsp_valid = lsu_rsp_valid_q;
  assign rsp_data      = rsp_data_q;
  assign rsp_err       = rsp_err_q;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_req_addr  = mem_req_addr_q;
  assign mem_req_wen   = mem_req_wen_q;
  assign mem_req_wdata = mem_req_wdata_q;
  assign mem_req_wmask = mem_req_wmask_q;

endmodule

// File: tb/tb_core_mem_arb.sv
module tb_core_mem_arb;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              ifu_req_valid = 1'b0;
  logic              ifu_req_ready;
  logic [ADDR_W-1:0] ifu_req_addr = '0;
  logic              lsu_req_valid = 1'b0;
  logic              lsu_req_ready;
  logic [ADDR_W-1:0] lsu_req_addr = '0;
  logic              lsu_req_wen = 1'b0;
  logic [DATA_W-1:0] lsu_req_wdata = '0;
  logic [7:0]        lsu_req_wmask = '0;
  logic              ifu_rsp_valid;
  logic              lsu_rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;
  logic              mem_req_valid;
  logic              mem_req_ready = 1'b0;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_req_wen;
  logic [DATA_W-1:0] mem_req_wdata;
  logic [7:0]        mem_req_wmask;
  logic              mem_rsp_valid = 1'b0;
  logic [DATA_W-1:0] mem_rsp_data = '0;

  int n_cmp = 0;
  int n_err = 0;

  core_mem_arb #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .STARVE_MAX(4),
    .TMO_CYC   (255)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ifu_req_valid(ifu_req_valid),
    .ifu_req_ready(ifu_req_ready),
    .ifu_req_addr (ifu_req_addr),
    .lsu_req_valid(lsu_req_valid),
    .lsu_req_ready(lsu_req_ready),
    .lsu_req_addr (lsu_req_addr),
    .lsu_req_wen  (lsu_req_wen),
    .lsu_req_wdata(lsu_req_wdata),
    .lsu_req_wmask(lsu_req_wmask),
    .ifu_rsp_valid(ifu_rsp_valid),
    .lsu_rsp_valid(lsu_rsp_valid),
    .rsp_data     (rsp_data),
    .rsp_err      (rsp_err),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_req_addr (mem_req_addr),
    .mem_req_wen  (mem_req_wen),
    .mem_req_wdata(mem_req_wdata),
    .mem_req_wmask(mem_req_wmask),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data (mem_rsp_data)
  );

  always #5 clk = ~clk;

  // Leaves the bench 1 ns after a rising edge; inputs are changed here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chkv(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic exp_l;
    int   n;

    // ---------------- reset values ----------------
    #2;
    chk1("rst_ifu_ready", ifu_req_ready, 1'b0);
    chk1("rst_lsu_ready", lsu_req_ready, 1'b0);
    chk1("rst_mem_req_valid", mem_req_valid, 1'b0);
    chk1("rst_ifu_rsp", ifu_rsp_valid, 1'b0);
    chk1("rst_lsu_rsp", lsu_rsp_valid, 1'b0);
    chk1("rst_err", rsp_err, 1'b0);
    chkv("rst_rsp_data", rsp_data, 64'h0);
    chkv("rst_mem_addr", 64'(mem_req_addr), 64'h0);
    chkv("rst_mem_wdata", mem_req_wdata, 64'h0);
    tick();
    tick();
    rst_n = 1'b1;
    settle();

    // ---------------- LSU beats IFU, REQ held 10 cycles ----------------
    ifu_req_valid = 1'b1;
    ifu_req_addr  = 32'h0000_4000;
    lsu_req_valid = 1'b1;
    lsu_req_addr  = 32'h0000_0100;
    lsu_req_wen   = 1'b1;
    lsu_req_wdata = 64'hDEAD_BEEF_CAFE_F00D;
    lsu_req_wmask = 8'hFF;
    settle();
    chk1("both_lsu_ready", lsu_req_ready, 1'b1);
    chk1("both_ifu_ready", ifu_req_ready, 1'b0);
    tick();
    // change LSU inputs; latched fields must not follow
    lsu_req_addr  = 32'h0000_0200;
    lsu_req_wen   = 1'b0;
    lsu_req_wdata = 64'h1111_2222_3333_4444;
    lsu_req_wmask = 8'h0F;
    mem_req_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      settle();
      chk1("stall_valid", mem_req_valid, 1'b1);
      chkv("stall_addr", 64'(mem_req_addr), 64'h100);
      chk1("stall_wen", mem_req_wen, 1'b1);
      chkv("stall_wmask", 64'(mem_req_wmask), 64'hFF);
      chkv("stall_wdata", mem_req_wdata, 64'hDEAD_BEEF_CAFE_F00D);
      chk1("stall_ifu_ready", ifu_req_ready, 1'b0);
      chk1("stall_lsu_ready", lsu_req_ready, 1'b0);
      tick();
    end
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 64'h55;
    settle();
    chk1("lsu_wait_req_valid", mem_req_valid, 1'b0);
    tick();
    mem_rsp_valid = 1'b0;
    settle();
    chk1("lsu_rsp_pulse", lsu_rsp_valid, 1'b1);
    chk1("lsu_rsp_ifu_quiet", ifu_rsp_valid, 1'b0);
    chkv("lsu_rsp_data", rsp_data, 64'h55);
    chk1("lsu_rsp_err", rsp_err, 1'b0);

    // ---------------- IFU minimum latency, granted in pulse cycle ----------------
    ifu_req_valid = 1'b1;
    ifu_req_addr  = 32'h8000_0000;
    settle();
    chk1("ifu_ready_in_pulse_cycle", ifu_req_ready, 1'b1);
    tick();
    ifu_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    settle();
    chk1("ifu_c1_req_valid", mem_req_valid, 1'b1);
    chkv("ifu_c1_addr", 64'(mem_req_addr), 64'h8000_0000);
    chk1("ifu_c1_wen", mem_req_wen, 1'b0);
    chkv("ifu_c1_wmask", 64'(mem_req_wmask), 64'h0);
    chkv("ifu_c1_wdata", mem_req_wdata, 64'h0);
    tick();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 64'h1234;
    settle();
    chk1("ifu_c2_req_valid", mem_req_valid, 1'b0);
    chk1("ifu_c2_no_rsp", ifu_rsp_valid, 1'b0);
    tick();
    mem_rsp_valid = 1'b0;
    settle();
    chk1("ifu_c3_rsp", ifu_rsp_valid, 1'b1);
    chk1("ifu_c3_lsu_quiet", lsu_rsp_valid, 1'b0);
    chkv("ifu_c3_data", rsp_data, 64'h1234);
    chk1("ifu_c3_err", rsp_err, 1'b0);
    tick();
    settle();
    chk1("ifu_c4_pulse_end", ifu_rsp_valid, 1'b0);

    // ---------------- starvation: L L L L I, twice ----------------
    ifu_req_valid = 1'b1;
    ifu_req_addr  = 32'h8000_1000;
    lsu_req_valid = 1'b1;
    lsu_req_addr  = 32'h0000_0300;
    lsu_req_wen   = 1'b0;
    lsu_req_wmask = 8'h00;
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b1;
    for (int g = 0; g < 10; g++) begin
      exp_l = ((g % 5) != 4);
      mem_rsp_data = 64'hA000 + 64'(g);
      settle();
      chk1("starve_lsu_ready", lsu_req_ready, exp_l);
      chk1("starve_ifu_ready", ifu_req_ready, ~exp_l);
      tick();
      tick();
      tick();
      settle();
      chk1("starve_lsu_rsp", lsu_rsp_valid, exp_l);
      chk1("starve_ifu_rsp", ifu_rsp_valid, ~exp_l);
      chkv("starve_rsp_data", rsp_data, 64'hA000 + 64'(g));
    end
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    tick();

    // ---------------- timeout: WAIT cycles with tmo 0..255 ----------------
    lsu_req_valid = 1'b1;
    lsu_req_addr  = 32'h0000_0400;
    lsu_req_wen   = 1'b1;
    lsu_req_wdata = 64'h1;
    lsu_req_wmask = 8'h01;
    settle();
    chk1("tmo_lsu_ready", lsu_req_ready, 1'b1);
    tick();
    lsu_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    n = 0;
    while (lsu_rsp_valid !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    chkv("tmo_latency", 64'(n), 64'd256);
    chk1("tmo_pulse", lsu_rsp_valid, 1'b1);
    chk1("tmo_err", rsp_err, 1'b1);
    chkv("tmo_data", rsp_data, 64'h0);
    chk1("tmo_ifu_quiet", ifu_rsp_valid, 1'b0);
    tick();
    tick();
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 64'hBAD;
    tick();
    mem_rsp_valid = 1'b0;
    settle();
    chk1("late_rsp_lsu", lsu_rsp_valid, 1'b0);
    chk1("late_rsp_ifu", ifu_rsp_valid, 1'b0);
    chk1("late_rsp_req_valid", mem_req_valid, 1'b0);
    tick();
    settle();
    chk1("late_rsp_lsu2", lsu_rsp_valid, 1'b0);

    // ---------------- response in the timeout cycle wins ----------------
    ifu_req_valid = 1'b1;
    ifu_req_addr  = 32'h8000_2000;
    settle();
    chk1("race_ifu_ready", ifu_req_ready, 1'b1);
    tick();
    ifu_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    repeat (255) tick();
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 64'h77;
    settle();
    chk1("race_no_early_tmo", ifu_rsp_valid, 1'b0);
    tick();
    mem_rsp_valid = 1'b0;
    settle();
    chk1("race_rsp", ifu_rsp_valid, 1'b1);
    chk1("race_err", rsp_err, 1'b0);
    chkv("race_data", rsp_data, 64'h77);

    // ---------------- reset during WAIT ----------------
    ifu_req_valid = 1'b1;
    ifu_req_addr  = 32'h8000_3000;
    tick();
    ifu_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    settle();
    chkv("prerst_addr", 64'(mem_req_addr), 64'h8000_3000);
    rst_n = 1'b0;
    #1;
    chkv("wrst_addr", 64'(mem_req_addr), 64'h0);
    chk1("wrst_req_valid", mem_req_valid, 1'b0);
    chkv("wrst_rsp_data", rsp_data, 64'h0);
    chk1("wrst_err", rsp_err, 1'b0);
    chk1("wrst_ifu_ready", ifu_req_ready, 1'b0);
    chk1("wrst_ifu_rsp", ifu_rsp_valid, 1'b0);
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 64'h99;
    tick();
    tick();
    chk1("wrst_no_pulse", ifu_rsp_valid, 1'b0);
    mem_rsp_valid = 1'b0;
    rst_n         = 1'b1;
    ifu_req_valid = 1'b1;
    ifu_req_addr  = 32'h8000_4000;
    settle();
    chk1("postrst_ifu_ready", ifu_req_ready, 1'b1);
    tick();
    ifu_req_valid = 1'b0;
    settle();
    chk1("postrst_req_valid", mem_req_valid, 1'b1);
    chkv("postrst_addr", 64'(mem_req_addr), 64'h8000_4000);
    chk1("postrst_no_pulse", ifu_rsp_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/core_mem_arb.md
CORE_MEM_ARB -- requirements
Module: core_mem_arb

Interface
REQ-001 Parameter ADDR_W, default 32, request address width.
REQ-002 Parameter DATA_W, default 64, data width.
REQ-003 Parameter STARVE_MAX, default 4, maximum consecutive LSU grants while IFU is pending.
REQ-004 Parameter TMO_CYC, default 255, response timeout in cycles (8-bit counter).
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 ifu_req_valid  input  1  fetch request.
REQ-008 ifu_req_ready  output  1  fetch request accepted.
REQ-009 ifu_req_addr  input  ADDR_W  fetch address.
REQ-010 lsu_req_valid  input  1  load/store request.
REQ-011 lsu_req_ready  output  1  load/store request accepted.
REQ-012 lsu_req_addr  input  ADDR_W  load/store address.
REQ-013 lsu_req_wen  input  1  1 = store.
REQ-014 lsu_req_wdata  input  DATA_W  store data.
REQ-015 lsu_req_wmask  input  8  store byte mask.
REQ-016 ifu_rsp_valid / lsu_rsp_valid  output  1 each  one-cycle response pulse to the owner.
REQ-017 rsp_data  output  DATA_W  response data, shared by both requesters.
REQ-018 rsp_err  output  1  response is a timeout error.
REQ-019 mem_req_valid  output  1  downstream request.
REQ-020 mem_req_ready  input  1  downstream accepts the request.
REQ-021 mem_req_addr / mem_req_wen / mem_req_wdata / mem_req_wmask  output  ADDR_W/1/DATA_W/8  latched request fields.
REQ-022 mem_rsp_valid  input  1  downstream response.
REQ-023 mem_rsp_data  input  DATA_W  downstream read data.

Function
REQ-024 FSM states: IDLE, REQ, WAIT; owner register (IFU/LSU); at most one outstanding transaction.
REQ-025 In IDLE, ready is asserted combinationally to the arbitration winner only when that winner's valid is high; the other ready is 0. In REQ and WAIT, both readies are 0.
REQ-026 Arbitration: LSU wins over IFU, except when starve_cnt == STARVE_MAX and ifu_req_valid is high; in that case IFU wins.
REQ-027 starve_cnt increments, saturating at STARVE_MAX, on an LSU grant with ifu_req_valid high. It clears on any IFU grant. It holds otherwise.
REQ-028 Grant (valid & ready): latch the fields and the owner, then go to REQ on the next cycle. An IFU grant latches wen=0, wdata=0, wmask=0.
REQ-029 In REQ, mem_req_valid=1 with the latched fields held stable. When mem_req_ready=1, go to WAIT and clear tmo_cnt.
REQ-030 In WAIT, tmo_cnt increments each cycle. When mem_rsp_valid=1: register rsp_data=mem_rsp_data and rsp_err=0, pulse the owner's rsp_valid on the next cycle, and go to IDLE.
REQ-031 In WAIT, when tmo_cnt reaches TMO_CYC without mem_rsp_valid: pulse the owner's rsp_valid next cycle with rsp_err=1 and rsp_data=0, then go to IDLE.
REQ-032 mem_rsp_valid is ignored outside WAIT, including a late response after a timeout.
REQ-033 If mem_rsp_valid arrives in the same cycle tmo_cnt hits TMO_CYC, the response wins (rsp_err=0).
REQ-034 A new grant is possible in the IDLE cycle in which the previous rsp_valid pulse is visible.
REQ-035 Minimum latency: grant in cycle 0, mem_req_valid in cycle 1; if mem_req_ready is high in cycle 1 and mem_rsp_valid in cycle 2, rsp_valid is in cycle 3.
REQ-036 mem_req_valid is 0 in IDLE and WAIT. rsp_valid pulses last exactly one cycle.

Reset
REQ-037 rst_n low asynchronously forces: state IDLE, owner IFU, starve_cnt 0, tmo_cnt 0, all valid/ready/err outputs 0, rsp_data 0, and mem_req fields 0.
REQ-038 Reset asserted during REQ or WAIT abandons the transaction without a response. After release, arbitration restarts from IDLE.

Verification
REQ-039 Scenario: ifu_req_valid=1, addr 0x8000_0000; mem_req_ready=1 at cycle 1; mem_rsp_valid at cycle 2 with data 0x1234. Required: ifu_rsp_valid at cycle 3, rsp_data=0x1234, rsp_err=0.
REQ-040 Scenario: IFU and LSU valid in the same cycle. Required: lsu_req_ready=1, ifu_req_ready=0, and mem_req_wen/wmask equal the LSU values (e.g. 1/0xFF).
REQ-041 Scenario: both requesters held valid continuously with single-cycle memory. Required: LSU gets 4 grants, the 5th grant goes to IFU, and starve_cnt returns to 0.
REQ-042 Scenario: mem_req_ready held low for 10 cycles. Required: mem_req_valid stays 1 with stable fields, and both readies stay 0.
REQ-043 Scenario: no mem_rsp_valid for 255 cycles in WAIT. Required: owner rsp_valid with rsp_err=1 and rsp_data=0; a mem_rsp_valid arriving 2 cycles later produces no pulse.
REQ-044 Scenario: rst_n low during WAIT. Required: all outputs read 0 immediately with no response pulse; a new IFU request is granted in the first cycle after release.
